// File: rtl/irq_controller_vec.sv
// irq_controller_vec
//   Multi-line, fixed-priority interrupt controller for a single-hart RISC-V
//   core. Each request line is level- or rising-edge-triggered (EDGE_MASK) and
//   individually masked. The lowest-index eligible line wins. Exception and
//   IRQ handler nesting is tracked so that mret returns from the right context
//   and acknowledges the serviced line.
//
// Ports
//   clk_i        core clock
//   rst_i        asynchronous, active-low reset
//   exception_i  synchronous exception raised this cycle
//   irq_req_i    raw request lines (already synchronous to clk_i)
//   irq_mask_i   per-line enable (mie CSR bits)
//   mie_i        global interrupt enable (mstatus.MIE)
//   mret_i       mret executed this cycle
//   irq_o        take-interrupt strobe (combinational, same cycle)
//   irq_cause_o  mcause value: winner while idle, active line while in handler
//   irq_ret_o    mret is returning from an IRQ handler
//   irq_ack_o    one-hot acknowledge of the serviced line, with irq_ret_o
//   irq_busy_o   an IRQ handler is active
module irq_controller_vec #(
  parameter int unsigned N_IRQ      = 16,
  parameter logic [31:0] EDGE_MASK  = 32'h0000_0000,
  parameter logic [31:0] CAUSE_BASE = 32'h1000_0010
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             exception_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [N_IRQ-1:0] irq_mask_i,
  input  logic             mie_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic             irq_ret_o,
  output logic [N_IRQ-1:0] irq_ack_o,
  output logic             irq_busy_o
);

  localparam int unsigned ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] edge_lines;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] prev_req;
  logic             exc_h;
  logic             irq_h;
  logic [ID_W-1:0]  active_id;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] eff_req;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] take_clr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  sel_id;
  logic             exc_set;

  assign edge_lines = EDGE_MASK[N_IRQ-1:0];

  // Edge lines are seen only through their pending latch; level lines pass
  // straight through and are never stored.
  assign rise    = irq_req_i & ~prev_req & edge_lines;
  assign eff_req = (pending & edge_lines) | (irq_req_i & ~edge_lines);
  // Gate with reset so every output sits at its idle value while in reset,
  // even if level requests are held high.
  assign eligible = eff_req & irq_mask_i & {N_IRQ{rst_i}};

  // Fixed priority: lowest set index wins.
  always_comb begin
    winner = '0;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (eligible[i-1]) winner = ID_W'(i - 1);
    end
  end

  assign exc_set   = exception_i | exc_h;
  assign irq_o     = mie_i & (|eligible) & ~exc_set & ~irq_h;
  assign irq_ret_o = mret_i & ~exc_set & irq_h;

  assign sel_id      = irq_h ? active_id : winner;
  assign irq_cause_o = CAUSE_BASE + 32'(sel_id);

  assign irq_ack_o  = irq_ret_o ? (N_IRQ'(1) << active_id) : '0;
  assign irq_busy_o = irq_h;

  assign take_clr = irq_o ? (N_IRQ'(1) << winner) : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending   <= '0;
      prev_req  <= '0;
      exc_h     <= 1'b0;
      irq_h     <= 1'b0;
      active_id <= '0;
    end else begin
      prev_req <= irq_req_i;
      // A new edge arriving on the cycle its line is taken must survive.
      pending  <= ((pending & ~take_clr) | rise) & edge_lines;
      exc_h    <= exc_set & ~mret_i;
      irq_h    <= (irq_h | irq_o) & ~irq_ret_o;
      if (irq_o) active_id <= winner;
    end
  end

endmodule

// File: tb/tb_irq_controller_vec.sv
module tb_irq_controller_vec;

  localparam int unsigned N = 16;
  localparam logic [31:0] CB = 32'h1000_0010;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          exception_i;
  logic [N-1:0]  irq_req_i;
  logic [N-1:0]  irq_mask_i;
  logic          mie_i;
  logic          mret_i;
  logic          irq_o;
  logic [31:0]   irq_cause_o;
  logic          irq_ret_o;
  logic [N-1:0]  irq_ack_o;
  logic          irq_busy_o;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  irq_controller_vec #(
    .N_IRQ     (N),
    .EDGE_MASK (32'h0000_0080),
    .CAUSE_BASE(CB)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .exception_i(exception_i),
    .irq_req_i  (irq_req_i),
    .irq_mask_i (irq_mask_i),
    .mie_i      (mie_i),
    .mret_i     (mret_i),
    .irq_o      (irq_o),
    .irq_cause_o(irq_cause_o),
    .irq_ret_o  (irq_ret_o),
    .irq_ack_o  (irq_ack_o),
    .irq_busy_o (irq_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled a little later, away from the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_i       = 1'b0;
    exception_i = 1'b0;
    irq_req_i   = '0;
    irq_mask_i  = '1;
    mie_i       = 1'b1;
    mret_i      = 1'b0;
    #2;
    chk("rst_irq",   32'(irq_o),      32'h0);
    chk("rst_cause", irq_cause_o,     CB);
    chk("rst_busy",  32'(irq_busy_o), 32'h0);
    chk("rst_ret",   32'(irq_ret_o),  32'h0);
    chk("rst_ack",   32'(irq_ack_o),  32'h0);
    step(); step();
    #2 rst_i = 1'b1;
    step();

    // mret with no handler active
    mret_i = 1'b1; settle();
    chk("idle_mret_ret", 32'(irq_ret_o), 32'h0);
    chk("idle_mret_ack", 32'(irq_ack_o), 32'h0);
    step(); mret_i = 1'b0;

    // single level line 3
    irq_req_i = 16'h0008; settle();
    chk("l3_irq",   32'(irq_o),  32'h1);
    chk("l3_cause", irq_cause_o, 32'h1000_0013);
    step();
    chk("l3_busy",   32'(irq_busy_o), 32'h1);
    chk("l3_no_nest", 32'(irq_o),     32'h0);
    chk("l3_cause_h", irq_cause_o,    32'h1000_0013);
    mret_i = 1'b1; settle();
    chk("l3_ret", 32'(irq_ret_o), 32'h1);
    chk("l3_ack", 32'(irq_ack_o), 32'h0008);
    step(); mret_i = 1'b0; irq_req_i = '0; settle();
    chk("l3_idle", 32'(irq_busy_o), 32'h0);

    // lines 5 and 2 together: 2 wins, 5 follows after return
    irq_req_i = 16'h0024; settle();
    chk("p_irq",   32'(irq_o),  32'h1);
    chk("p_cause", irq_cause_o, 32'h1000_0012);
    step();
    irq_req_i = 16'h0020; mret_i = 1'b1; settle();
    chk("p_ret",  32'(irq_ret_o), 32'h1);
    chk("p_ack",  32'(irq_ack_o), 32'h0004);
    chk("p_wait", 32'(irq_o),     32'h0);
    step(); mret_i = 1'b0; settle();
    chk("p2_irq",   32'(irq_o),  32'h1);
    chk("p2_cause", irq_cause_o, 32'h1000_0015);
    step();
    mret_i = 1'b1; irq_req_i = '0; settle();
    chk("p2_ack", 32'(irq_ack_o), 32'h0020);
    step(); mret_i = 1'b0;

    // edge line 7 pulsed while globally disabled
    mie_i = 1'b0; irq_req_i = 16'h0080; settle();
    chk("e_off", 32'(irq_o), 32'h0);
    step(); irq_req_i = '0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("e_held", 32'(irq_o), 32'h0);
      step();
    end
    mie_i = 1'b1; settle();
    chk("e_irq",   32'(irq_o),  32'h1);
    chk("e_cause", irq_cause_o, 32'h1000_0017);
    step();
    mret_i = 1'b1; settle();
    chk("e_ack", 32'(irq_ack_o), 32'h0080);
    step(); mret_i = 1'b0; settle();
    chk("e_noretrig", 32'(irq_o), 32'h0);
    step(); settle();
    chk("e_noretrig2", 32'(irq_o), 32'h0);

    // exception and line 0 in the same cycle
    exception_i = 1'b1; irq_req_i = 16'h0001; settle();
    chk("x_irq", 32'(irq_o), 32'h0);
    step(); exception_i = 1'b0; settle();
    chk("x_irq_h",  32'(irq_o),      32'h0);
    chk("x_busy",   32'(irq_busy_o), 32'h0);
    mret_i = 1'b1; settle();
    chk("x_ret", 32'(irq_ret_o), 32'h0);
    step(); mret_i = 1'b0; settle();
    chk("x_irq2",  32'(irq_o),  32'h1);
    chk("x_cause", irq_cause_o, 32'h1000_0010);
    step();
    mret_i = 1'b1; irq_req_i = '0; settle();
    chk("x_ack", 32'(irq_ack_o), 32'h0001);
    step(); mret_i = 1'b0;

    // exception nested inside an IRQ handler
    irq_req_i = 16'h0008; settle();
    chk("n_irq", 32'(irq_o), 32'h1);
    step(); irq_req_i = '0; exception_i = 1'b1; settle();
    step(); exception_i = 1'b0; mret_i = 1'b1; settle();
    chk("n_ret1", 32'(irq_ret_o), 32'h0);
    chk("n_ack1", 32'(irq_ack_o), 32'h0);
    step(); mret_i = 1'b0; settle();
    chk("n_busy", 32'(irq_busy_o), 32'h1);
    mret_i = 1'b1; settle();
    chk("n_ret2", 32'(irq_ret_o), 32'h1);
    chk("n_ack2", 32'(irq_ack_o), 32'h0008);
    step(); mret_i = 1'b0; settle();
    chk("n_done", 32'(irq_busy_o), 32'h0);

    // async reset mid-handler with an edge pending
    irq_req_i = 16'h0008; settle();
    chk("r_irq", 32'(irq_o), 32'h1);
    step(); irq_req_i = 16'h0080;
    step(); irq_req_i = '0;
    #2 rst_i = 1'b0;
    #1;
    chk("r_busy",  32'(irq_busy_o), 32'h0);
    chk("r_irq0",  32'(irq_o),      32'h0);
    chk("r_cause", irq_cause_o,     CB);
    step();
    #2 rst_i = 1'b1;
    step(); settle();
    chk("r_stale", 32'(irq_o), 32'h0);
    step(); settle();
    chk("r_stale2", 32'(irq_o),      32'h0);
    chk("r_busy2",  32'(irq_busy_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/irq_controller_vec.md
Name: irq_controller_vec

Overview:
- Multi-line, priority-resolving interrupt controller for the single-hart RISC-V core; replaces the single-line controller.
- Accepts N_IRQ request lines, each with its own level or edge mode and mask. Selects the highest-priority enabled request and signals the CSR/trap logic with irq_o and irq_cause_o.
- Tracks exception/IRQ handler nesting so mret returns from the correct context. Acknowledges the serviced line to the peripheral on return.

Parameters:
- N_IRQ, 16, number of request lines (1..32); index 0 is highest priority.
- EDGE_MASK, 32'h0000_0000, bit k=1 makes line k edge-triggered (rising); 0 makes it level-triggered.
- CAUSE_BASE, 32'h1000_0010, cause value for line 0; line k reports CAUSE_BASE + k.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset; asynchronous, active-low.
- exception_i  in  1  synchronous exception from the core this cycle.
- irq_req_i  in  N_IRQ  raw request lines, already synchronous to clk_i.
- irq_mask_i  in  N_IRQ  per-line enable (1 = enabled); driven from the mie CSR bits.
- mie_i  in  1  global interrupt enable (mstatus.MIE).
- mret_i  in  1  mret executed this cycle.
- irq_o  out  1  take-interrupt strobe to the trap logic.
- irq_cause_o  out  32  mcause value for the interrupt being taken.
- irq_ret_o  out  1  mret is returning from an IRQ handler.
- irq_ack_o  out  N_IRQ  one-hot, one-cycle acknowledge of the serviced line, asserted with irq_ret_o.
- irq_busy_o  out  1  an IRQ handler is active.

Behaviour:
- Reset (rst_i=0, async): pending=0, prev_req=0, exc_h=0, irq_h=0, active_id=0. All outputs are 0, except irq_cause_o = CAUSE_BASE.
- Edge lines: pending[k] is set on the cycle where irq_req_i[k]=1 and prev_req[k]=0. It is cleared on the cycle the line is taken (irq_o=1 with winner k). If set and clear coincide, set wins. prev_req is registered every cycle.
- Level lines: the effective request is irq_req_i[k] directly; no storage. The peripheral deasserts its line after irq_ack_o.
- Eligible vector: eff_req & irq_mask_i. The winner is the lowest set index (fixed priority).
- Handler state follows the two flags exc_h and irq_h:
  - exc_set = exception_i | exc_h.
  - irq_o = mie_i & (eligible != 0) & ~exc_set & ~irq_h. This is combinational, same-cycle, with zero latency.
  - irq_cause_o = CAUSE_BASE + winner while idle, and CAUSE_BASE + active_id while irq_h=1. Arithmetic is 32-bit with wrap-around.
  - On irq_o: irq_h <= 1 and active_id <= winner.
  - exc_h <= exc_set & ~mret_i. An exception inside an IRQ handler nests, and the first mret clears exc_h only.
  - irq_ret_o = mret_i & ~exc_set & irq_h.
  - irq_h <= (irq_h | irq_o) & ~irq_ret_o.
  - irq_ack_o = irq_ret_o ? onehot(active_id) : 0.
  - irq_busy_o = irq_h (registered).
- Simultaneous exception_i and eligible request: the exception wins and irq_o=0. The request stays pending and is taken after the exception handler's mret.
- mret with exc_h=0 and irq_h=0: no effect; irq_ret_o=0.
- irq_mask_i or mie_i deasserted while an edge line is pending: pending is held and taken when re-enabled.
- No nesting of IRQs: a higher-priority request during an active IRQ handler waits for irq_ret_o. It can be taken in the cycle after irq_ret_o at the earliest.
- Reset asserted mid-handler: all state clears immediately; pending edges are lost.

Test Plan:
- Single level line 3 (mask=1, mie=1) asserted -> same cycle irq_o=1, irq_cause_o=0x1000_0013. Next cycle irq_busy_o=1. mret -> irq_ret_o=1, irq_ack_o=0x0008.
- Lines 5 and 2 asserted together -> irq_cause_o=0x1000_0012. After mret with line 2 dropped and line 5 still high -> second irq_o with cause 0x1000_0015 one cycle after irq_ret_o.
- Edge line 7 (EDGE_MASK bit 7) pulsed 1 cycle while mie=0 -> no irq_o. mie raised 10 cycles later -> irq_o=1, cause 0x1000_0017. Pending clears; no retrigger.
- exception_i and line 0 asserted in the same cycle -> irq_o=0. mret -> irq_ret_o=0. Next cycle irq_o=1, cause 0x1000_0010.
- During an IRQ handler, exception_i pulse -> first mret gives irq_ret_o=0 and irq_busy_o stays 1. Second mret gives irq_ret_o=1 and the ack for the active line.
- rst_i driven low mid-handler, asynchronously between clock edges -> irq_busy_o=0, irq_o=0, pending=0 immediately. After release, a stale edge is not taken.
